// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: word widths, jump opcodes and the fetch state encoding.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_JAL = 6'b000011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    NEXT = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/fetch_timeout_cnt.sv
// Counts consecutive cycles with run_i high; expired_o marks the last allowed cycle.
// Only built when IFETCH_TIMEOUT_EN is defined.
`ifdef IFETCH_TIMEOUT_EN
module fetch_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/instr_fetch_mips.sv
// Instruction fetch: PC -> imem req/ack -> held word for decode; best case 3 cycles/instr, decode stalls via instr_ready.
// IFETCH_TIMEOUT_EN adds a sticky fetch_err and halt when mem_ack never arrives.
module instr_fetch_mips
  import mips_pkg::*;
#(
  parameter logic [5:0] OPC_J   = mips_pkg::OPC_J,
  parameter logic [5:0] OPC_JAL = mips_pkg::OPC_JAL
`ifdef IFETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_ptr,
  output logic               pc_advance,
  output logic               is_jump,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready
`ifdef IFETCH_TIMEOUT_EN
  , output logic             fetch_err
`endif
);
  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               halt;
  logic               expired;
  logic               pc_lsb_unused;

  // Byte offset of the PC is dropped silently; fetches are word-aligned.
  assign pc_lsb_unused = ^pc_ptr[1:0];

`ifdef IFETCH_TIMEOUT_EN
  logic err_q, err_d;

  fetch_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_n    (reset),
    .run_i    (state_q == REQ),
    .expired_o(expired)
  );

  always_comb begin
    err_d = err_q;
    if (state_q == REQ && !mem_ack && expired) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign halt      = err_q;
  assign fetch_err = err_q;
`else
  assign halt    = 1'b0;
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!halt) state_d = REQ;
      REQ: begin
        if (mem_ack)      state_d = HOLD;
        else if (expired) state_d = IDLE;
      end
      HOLD: if (instr_ready) state_d = NEXT;
      NEXT: state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req     = (state_q == REQ);
    instr_valid = (state_q == HOLD);
    pc_advance  = (state_q == HOLD) && instr_ready;
    is_jump     = pc_advance &&
                  (instr_q[31:26] == OPC_J || instr_q[31:26] == OPC_JAL);
  end

  always_comb begin
    addr_d  = addr_q;
    instr_d = instr_q;
    if ((state_q == IDLE && !halt) || state_q == NEXT)
      addr_d = {pc_ptr[ADDR_W-1:2], 2'b00};
    if (state_q == REQ && mem_ack)
      instr_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  assign mem_addr = addr_q;
  assign instr    = instr_q;
endmodule

// File: doc/instr_fetch_mips.md
Name: instr_fetch_mips

Overview:
- Fetch-side counterpart of the MIPS program counter.
- Takes the PC pointer and reads one 32-bit word from instruction memory over a req/ack handshake.
- Holds the word for the decode stage until it is consumed, then returns `is_jump` plus a one-cycle advance strobe to the PC.
- Sits between the program counter, instruction memory and decode.

Parameters:
- TIMEOUT_CYCLES, 16, cycles allowed for mem_ack before a fetch error (used only with the optional feature).
- OPC_J, 6'b000010, opcode of J.
- OPC_JAL, 6'b000011, opcode of JAL.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- pc_ptr  in  32  current PC value.
- pc_advance  out  1  one-cycle strobe; PC updates on the clk edge where it is 1.
- is_jump  out  1  current word is J/JAL; valid only while pc_advance=1.
- mem_req  out  1  memory read request.
- mem_addr  out  32  word-aligned read address.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  32  read data.
- instr  out  32  held instruction word.
- instr_valid  out  1  instr valid for decode.
- instr_ready  in  1  decode accepts instr.
- fetch_err  out  1  sticky fetch timeout flag (present only with the optional feature).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, mem_req=0, mem_addr=0, instr=0, instr_valid=0, pc_advance=0, is_jump=0, fetch_err=0. Reset mid-transaction abandons the fetch; a late mem_ack after reset is ignored.
- IDLE: on the first clk after reset deasserts, latch mem_addr={pc_ptr[31:2],2'b00} and go to REQ.
- REQ:
  - mem_req=1; mem_addr stays stable until ack.
  - On mem_ack=1: capture instr=mem_rdata, set instr_valid=1, drop mem_req the next cycle, go to HOLD.
  - Ack in the same cycle req rises is legal, giving 1-cycle latency.
- HOLD:
  - instr_valid=1; instr stays stable.
  - On instr_valid&instr_ready: pulse pc_advance for exactly that cycle, with is_jump=(instr[31:26]==OPC_J || instr[31:26]==OPC_JAL). Go to NEXT.
  - instr_valid clears the following cycle.
- NEXT: one bubble cycle so the PC update settles. Latch mem_addr from the new pc_ptr, then go to REQ.
- Throughput: best case 1 instruction per 3 cycles (REQ, HOLD, NEXT).
- is_jump=0 whenever pc_advance=0.
- mem_ack in IDLE, HOLD or NEXT is ignored; no data is overwritten.
- instr_ready held high continuously: consumption occurs in the first HOLD cycle.
- pc_ptr[1:0]≠0: bits are dropped; no error is raised.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in REQ and clears on leaving REQ.
  - If it reaches TIMEOUT_CYCLES without mem_ack: set fetch_err=1 (sticky until reset), deassert mem_req, go to IDLE-halt. The block never leaves IDLE-halt until reset.
- Without the macro: the fetch_err port and counter are absent; REQ waits indefinitely.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OPC_J and OPC_JAL;
  - the fetch state enum (IDLE, REQ, HOLD, NEXT);
  - the INSTR_W=32 and ADDR_W=32 constants.
- No sub-module, except under IFETCH_TIMEOUT_EN: a small timeout counter, fetch_timeout_cnt.

Test Plan:
- Reset check: hold reset=0 while mem_ack toggles -> all outputs 0, mem_req stays 0.
- Single fetch, 1-cycle ack:
  - Stimulus: pc_ptr=0x00000010, mem_rdata=0x8C220004 (lw), instr_ready=1.
  - Response: mem_addr=0x10, instr=0x8C220004, pc_advance 1-cycle pulse, is_jump=0.
- Jump decode:
  - Stimulus: mem_rdata=0x08000040 (J).
  - Response: is_jump=1 coincident with pc_advance.
  - Also: 0x0C000040 (JAL) -> is_jump=1.
- Backpressure and late ack:
  - Stimulus: mem_ack delayed 5 cycles; instr_ready low 4 cycles.
  - Response: mem_addr stable throughout; instr stable; pc_advance only when instr_ready rises.
  - Also: a stray mem_ack in HOLD does not change instr.
- Reset mid-REQ: assert reset during REQ, release, then give a late mem_ack -> ignored; a fresh fetch restarts from IDLE.
- Timeout (IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16): never ack -> fetch_err=1 after 16 REQ cycles, mem_req=0, stays halted until reset.
